ex_hazard_ctrl: RTL and testbench
=================================

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64; max cycles the MDU may stay busy before abort.
REQ-002 SHALL have parameter CNT_W, default 32; width of the stall counter.
REQ-003 SHALL have port iClk, input, 1; the single clock, all state on its rising edge.
REQ-004 SHALL have port iRst, input, 1; reset, asynchronous and active-high.
REQ-005 SHALL have inputs iEx_valid (1), iEx_rs1_addr (5), iEx_rs2_addr (5), iEx_rs1_used (1), iEx_rs2_used (1), iEx_is_mdu (1); these describe the instruction in EX.
REQ-006 SHALL have inputs iExMe_rd_addr (5), iExMe_wr_en (1), iExMe_is_load (1); these describe the EX/MEM producer.
REQ-007 SHALL have inputs iMeWb_rd_addr (5), iMeWb_wr_en (1); these describe the MEM/WB producer.
REQ-008 SHALL have inputs iFlush (1), pipeline flush, and iMdu_done (1), MDU result valid.
REQ-009 SHALL have outputs oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en (1 each); these are the EX operand forward selects.
REQ-010 SHALL have outputs oStall (1), hold IF/ID/EX, and oBubble (1), write NOP into EX/MEM.
REQ-011 SHALL have outputs oMdu_start (1) and oMdu_abort (1), one-cycle MDU pulses.
REQ-012 SHALL have outputs oMdu_err (1), a timeout pulse, and oStallCnt (CNT_W), the stall cycle count.

Function
REQ-013 SHALL define the operand match for Sn as: iEx_valid & iEx_rsN_used & rsN_addr != 0 & producer wr_en & rd_addr == rsN_addr.
REQ-014 SHALL assert oFwExSn_en on an EX/MEM match that is not a load, combinationally.
REQ-015 SHALL assert oFwMeSn_en on a MEM/WB match only when no EX/MEM match exists for that operand; EX/MEM has priority as the younger producer.
REQ-016 SHALL never assert oFwExSn_en and oFwMeSn_en together for the same operand.
REQ-017 SHALL treat an EX/MEM match with iExMe_is_load=1 as load-use.
REQ-018 SHALL, on load-use, assert oStall=1 and oBubble=1 and leave both forward enables for that operand at 0 in that cycle.
REQ-019 SHALL clear the load-use stall after exactly 1 cycle, once the load reaches MEM/WB and oFwMeSn_en takes over.
REQ-020 SHALL implement the MDU FSM with states IDLE and BUSY.
REQ-021 SHALL, in IDLE with iEx_valid & iEx_is_mdu & !iFlush & no load-use: pulse oMdu_start for 1 cycle, assert oStall, clear the timeout counter, and go to BUSY.
REQ-022 SHALL, when load-use and an MDU op coincide, resolve load-use first and start the MDU in the next cycle.
REQ-023 SHALL, in BUSY with !iMdu_done: keep oStall=1 and increment the timeout counter.
REQ-024 SHALL, in BUSY with iMdu_done=1: drive oStall=0 in that same cycle so EX advances, and return to IDLE.
REQ-025 SHALL, in BUSY with the timeout counter at MDU_TIMEOUT-1 and no done: pulse oMdu_err and oMdu_abort, drive oStall=0, and return to IDLE.
REQ-026 SHALL, on iFlush in BUSY: pulse oMdu_abort, drive oStall=0, return to IDLE, and let iFlush override iMdu_done in the same cycle.
REQ-027 SHALL ignore iMdu_done in IDLE.
REQ-028 SHALL gate iFlush so that it never causes oStall or oBubble in the same cycle.
REQ-029 SHALL increment oStallCnt by 1 on every cycle with oStall=1, saturating at all-ones with no wrap.
REQ-030 SHALL keep oMdu_start, oMdu_abort and oMdu_err as registered-FSM-derived pulses with no glitch across state changes.

Reset
REQ-031 SHALL on iRst=1, asynchronously, force the FSM to IDLE and clear the timeout counter and oStallCnt to 0.
REQ-032 SHALL hold all outputs at 0 while iRst=1.
REQ-033 SHALL, on reset mid-BUSY, emit no oMdu_abort pulse; the MDU is reset by the same iRst.
REQ-034 SHALL start normal operation on the first rising iClk edge after iRst deasserts.

Verification
REQ-035 SHALL cover this case: EX/MEM rd=5 non-load wr_en=1, MEM/WB rd=5 wr_en=1, EX rs1=5 used -> oFwExS1_en=1, oFwMeS1_en=0, oStall=0.
REQ-036 SHALL cover this case: EX rs2=0 used, producers rd=0 wr_en=1 -> all forward enables 0.
REQ-037 SHALL cover this case: EX/MEM load rd=7, EX rs2=7 used -> cycle 0 oStall=1, oBubble=1; cycle 1 load in MEM/WB -> oFwMeS2_en=1, oStall=0; oStallCnt=1.
REQ-038 SHALL cover this case: MDU op in EX, iMdu_done at cycle 4 -> oMdu_start pulse at cycle 0, oStall high for cycles 0-3 and low at cycle 4, FSM in IDLE at cycle 5.
REQ-039 SHALL cover this case: MDU op with iMdu_done never asserted, MDU_TIMEOUT=8 -> oMdu_err and oMdu_abort pulse exactly once at cycle 8, then oStall=0.
REQ-040 SHALL cover this case: iFlush at cycle 2 of BUSY together with iMdu_done -> oMdu_abort=1, no oMdu_err; also iRst mid-BUSY -> all outputs 0 immediately and oStallCnt=0.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding selects, load-use stall/bubble,
// and a two-state multiply/divide unit sequencer with timeout and stall counter.
module ex_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEx_valid,
    input  logic [4:0]       iEx_rs1_addr,
    input  logic [4:0]       iEx_rs2_addr,
    input  logic             iEx_rs1_used,
    input  logic             iEx_rs2_used,
    input  logic             iEx_is_mdu,
    input  logic [4:0]       iExMe_rd_addr,
    input  logic             iExMe_wr_en,
    input  logic             iExMe_is_load,
    input  logic [4:0]       iMeWb_rd_addr,
    input  logic             iMeWb_wr_en,
    input  logic             iFlush,
    input  logic             iMdu_done,
    output logic             oFwExS1_en,
    output logic             oFwExS2_en,
    output logic             oFwMeS1_en,
    output logic             oFwMeS2_en,
    output logic             oStall,
    output logic             oBubble,
    output logic             oMdu_start,
    output logic             oMdu_abort,
    output logic             oMdu_err,
    output logic [CNT_W-1:0] oStallCnt
);

    localparam int TO_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mduState_t;

    mduState_t       stateReg, stateNext;
    logic [TO_W-1:0] toCntReg, toCntNext;
    logic [CNT_W-1:0] stallCntReg;

    logic [1:0][4:0] rsAddr;
    logic [1:0]      rsUsed;
    logic [1:0]      exMatch, meMatch, fwEx, fwMe;
    logic            loadUse, loadStall;
    logic            mduStall, mduStart, mduAbort, mduErr;
    logic            stallRaw;

    assign rsAddr = {iEx_rs2_addr, iEx_rs1_addr};
    assign rsUsed = {iEx_rs2_used, iEx_rs1_used};

    // Per-operand matching; EX/MEM is the younger producer and wins over MEM/WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gOperand
            assign exMatch[gi] = iEx_valid & rsUsed[gi] & (rsAddr[gi] != 5'd0)
                               & iExMe_wr_en & (iExMe_rd_addr == rsAddr[gi]);
            assign meMatch[gi] = iEx_valid & rsUsed[gi] & (rsAddr[gi] != 5'd0)
                               & iMeWb_wr_en & (iMeWb_rd_addr == rsAddr[gi]);
            assign fwEx[gi]    = exMatch[gi] & ~iExMe_is_load;
            assign fwMe[gi]    = meMatch[gi] & ~exMatch[gi];
        end
    endgenerate

    assign loadUse   = (|exMatch) & iExMe_is_load;
    assign loadStall = loadUse & ~iFlush;

    always_comb begin
        stateNext = stateReg;
        toCntNext = toCntReg;
        mduStart  = 1'b0;
        mduAbort  = 1'b0;
        mduErr    = 1'b0;
        mduStall  = 1'b0;
        case (stateReg)
            IDLE: begin
                // A pending load-use takes precedence; the MDU launches a cycle later.
                if (iEx_valid & iEx_is_mdu & ~iFlush & ~loadUse) begin
                    mduStart  = 1'b1;
                    mduStall  = 1'b1;
                    toCntNext = '0;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (iFlush) begin
                    mduAbort  = 1'b1;
                    stateNext = IDLE;
                end else if (iMdu_done) begin
                    stateNext = IDLE;
                end else if (toCntReg == TO_LAST) begin
                    mduErr    = 1'b1;
                    mduAbort  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    mduStall  = 1'b1;
                    toCntNext = toCntReg + TO_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign stallRaw = loadStall | mduStall;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateReg <= IDLE;
            toCntReg <= '0;
        end else begin
            stateReg <= stateNext;
            toCntReg <= toCntNext;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stallCntReg <= '0;
        end else if (stallRaw && (stallCntReg != {CNT_W{1'b1}})) begin
            stallCntReg <= stallCntReg + CNT_W'(1);
        end
    end

    // Everything is forced low while reset is held, so a reset mid-BUSY never aborts.
    assign oFwExS1_en = fwEx[0] & ~iRst;
    assign oFwExS2_en = fwEx[1] & ~iRst;
    assign oFwMeS1_en = fwMe[0] & ~iRst;
    assign oFwMeS2_en = fwMe[1] & ~iRst;
    assign oStall     = stallRaw & ~iRst;
    assign oBubble    = loadStall & ~iRst;
    assign oMdu_start = mduStart & ~iRst;
    assign oMdu_abort = mduAbort & ~iRst;
    assign oMdu_err   = mduErr & ~iRst;
    assign oStallCnt  = stallCntReg;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: rule-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_hazard_ctrl;

    localparam int TO    = 8;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iEx_valid = 1'b0;
    logic [4:0]    iEx_rs1_addr = '0;
    logic [4:0]    iEx_rs2_addr = '0;
    logic          iEx_rs1_used = 1'b0;
    logic          iEx_rs2_used = 1'b0;
    logic          iEx_is_mdu = 1'b0;
    logic [4:0]    iExMe_rd_addr = '0;
    logic          iExMe_wr_en = 1'b0;
    logic          iExMe_is_load = 1'b0;
    logic [4:0]    iMeWb_rd_addr = '0;
    logic          iMeWb_wr_en = 1'b0;
    logic          iFlush = 1'b0;
    logic          iMdu_done = 1'b0;
    logic          oFwExS1_en, oFwExS2_en, oFwMeS1_en, oFwMeS2_en;
    logic          oStall, oBubble, oMdu_start, oMdu_abort, oMdu_err;
    logic [CW-1:0] oStallCnt;

    int errors = 0;
    int checks = 0;

    ex_hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
        .iClk(iClk), .iRst(iRst),
        .iEx_valid(iEx_valid), .iEx_rs1_addr(iEx_rs1_addr), .iEx_rs2_addr(iEx_rs2_addr),
        .iEx_rs1_used(iEx_rs1_used), .iEx_rs2_used(iEx_rs2_used), .iEx_is_mdu(iEx_is_mdu),
        .iExMe_rd_addr(iExMe_rd_addr), .iExMe_wr_en(iExMe_wr_en), .iExMe_is_load(iExMe_is_load),
        .iMeWb_rd_addr(iMeWb_rd_addr), .iMeWb_wr_en(iMeWb_wr_en),
        .iFlush(iFlush), .iMdu_done(iMdu_done),
        .oFwExS1_en(oFwExS1_en), .oFwExS2_en(oFwExS2_en),
        .oFwMeS1_en(oFwMeS1_en), .oFwMeS2_en(oFwMeS2_en),
        .oStall(oStall), .oBubble(oBubble),
        .oMdu_start(oMdu_start), .oMdu_abort(oMdu_abort), .oMdu_err(oMdu_err),
        .oStallCnt(oStallCnt)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit mdlBusy   = 1'b0;
    int mdlAge    = 0;    // cycles already spent waiting in BUSY
    int mdlStalls = 0;

    bit expFwEx1, expFwEx2, expFwMe1, expFwMe2;
    bit expStall, expBubble, expStart, expAbort, expErr;

    function automatic bit hits(input bit used, input logic [4:0] rs, input bit wr, input logic [4:0] rd);
        return iEx_valid && used && (rs != 0) && wr && (rd == rs);
    endfunction

    always_comb begin
        bit e1, e2, m1, m2, ldUse, ldStall, timedOut, finish;
        e1 = hits(iEx_rs1_used, iEx_rs1_addr, iExMe_wr_en, iExMe_rd_addr);
        e2 = hits(iEx_rs2_used, iEx_rs2_addr, iExMe_wr_en, iExMe_rd_addr);
        m1 = hits(iEx_rs1_used, iEx_rs1_addr, iMeWb_wr_en, iMeWb_rd_addr);
        m2 = hits(iEx_rs2_used, iEx_rs2_addr, iMeWb_wr_en, iMeWb_rd_addr);
        ldUse    = (e1 || e2) && iExMe_is_load;
        ldStall  = ldUse && !iFlush;
        timedOut = mdlBusy && (mdlAge == TO - 1);
        finish   = iFlush || iMdu_done || timedOut;
        expFwEx1  = e1 && !iExMe_is_load;
        expFwEx2  = e2 && !iExMe_is_load;
        expFwMe1  = m1 && !e1;
        expFwMe2  = m2 && !e2;
        expBubble = ldStall;
        expStart  = !mdlBusy && iEx_valid && iEx_is_mdu && !iFlush && !ldUse;
        expStall  = ldStall || expStart || (mdlBusy && !finish);
        expAbort  = mdlBusy && (iFlush || (timedOut && !iMdu_done));
        expErr    = timedOut && !iFlush && !iMdu_done;
        if (iRst) begin
            expFwEx1 = 0; expFwEx2 = 0; expFwMe1 = 0; expFwMe2 = 0;
            expStall = 0; expBubble = 0; expStart = 0; expAbort = 0; expErr = 0;
        end
    end

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mdlBusy   <= 1'b0;
            mdlAge    <= 0;
            mdlStalls <= 0;
        end else begin
            if (expStall && mdlStalls < MAXC) mdlStalls <= mdlStalls + 1;
            if (!mdlBusy) begin
                if (expStart) begin
                    mdlBusy <= 1'b1;
                    mdlAge  <= 0;
                end
            end else if (iFlush || iMdu_done || mdlAge == TO - 1) begin
                mdlBusy <= 1'b0;
            end else begin
                mdlAge <= mdlAge + 1;
            end
        end
    end

    always @(negedge iClk) begin
        check("mdl_fwExS1", oFwExS1_en, expFwEx1);
        check("mdl_fwExS2", oFwExS2_en, expFwEx2);
        check("mdl_fwMeS1", oFwMeS1_en, expFwMe1);
        check("mdl_fwMeS2", oFwMeS2_en, expFwMe2);
        check("mdl_stall",  oStall,     expStall);
        check("mdl_bubble", oBubble,    expBubble);
        check("mdl_start",  oMdu_start, expStart);
        check("mdl_abort",  oMdu_abort, expAbort);
        check("mdl_err",    oMdu_err,   expErr);
        check("mdl_cnt",    oStallCnt,  mdlStalls);
    end

    // ---------------- directed stimulus ----------------
    task automatic nextCycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic mid(input string step);
        @(negedge iClk);
        $display("[%0t] step %s stall=%0b bubble=%0b start=%0b abort=%0b err=%0b cnt=%0d",
                 $time, step, oStall, oBubble, oMdu_start, oMdu_abort, oMdu_err, oStallCnt);
    endtask

    task automatic idleInputs();
        iEx_valid = 0; iEx_rs1_addr = 0; iEx_rs2_addr = 0; iEx_rs1_used = 0; iEx_rs2_used = 0;
        iEx_is_mdu = 0; iExMe_rd_addr = 0; iExMe_wr_en = 0; iExMe_is_load = 0;
        iMeWb_rd_addr = 0; iMeWb_wr_en = 0; iFlush = 0; iMdu_done = 0;
    endtask

    task automatic mduOp();
        idleInputs();
        iEx_valid = 1; iEx_is_mdu = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mid("reset");
        check("rst_stall", oStall, 0);
        check("rst_cnt", oStallCnt, 0);
        nextCycle();
        iRst = 0;

        // EX/MEM and MEM/WB both write x5: younger producer wins
        nextCycle();
        idleInputs();
        iEx_valid = 1; iEx_rs1_addr = 5; iEx_rs1_used = 1;
        iExMe_rd_addr = 5; iExMe_wr_en = 1; iMeWb_rd_addr = 5; iMeWb_wr_en = 1;
        mid("fwd_priority");
        check("prio_fwEx1", oFwExS1_en, 1);
        check("prio_fwMe1", oFwMeS1_en, 0);
        check("prio_stall", oStall, 0);

        // x0 is never forwarded
        nextCycle();
        idleInputs();
        iEx_valid = 1; iEx_rs2_used = 1; iEx_rs1_used = 1;
        iExMe_wr_en = 1; iMeWb_wr_en = 1;
        mid("x0");
        check("x0_fwEx2", oFwExS2_en, 0);
        check("x0_fwMe2", oFwMeS2_en, 0);

        // MEM/WB-only match on rs2; rs1 matches EX/MEM address but no write
        nextCycle();
        idleInputs();
        iEx_valid = 1; iEx_rs1_addr = 12; iEx_rs1_used = 1; iEx_rs2_addr = 9; iEx_rs2_used = 1;
        iExMe_rd_addr = 12; iMeWb_rd_addr = 9; iMeWb_wr_en = 1;
        mid("fwd_mewb");
        check("mewb_fwMe2", oFwMeS2_en, 1);
        check("mewb_fwEx1", oFwExS1_en, 0);

        // load-use on rs2, then load reaches MEM/WB
        nextCycle();
        idleInputs();
        iEx_valid = 1; iEx_rs2_addr = 7; iEx_rs2_used = 1;
        iExMe_rd_addr = 7; iExMe_wr_en = 1; iExMe_is_load = 1;
        mid("load_use0");
        check("lu_stall", oStall, 1);
        check("lu_bubble", oBubble, 1);
        check("lu_fwEx2", oFwExS2_en, 0);
        check("lu_fwMe2", oFwMeS2_en, 0);
        nextCycle();
        iExMe_rd_addr = 0; iExMe_wr_en = 0; iExMe_is_load = 0;
        iMeWb_rd_addr = 7; iMeWb_wr_en = 1;
        mid("load_use1");
        check("lu1_fwMe2", oFwMeS2_en, 1);
        check("lu1_stall", oStall, 0);
        check("lu1_cnt", oStallCnt, 1);

        // MDU op, done on cycle 4
        nextCycle();
        mduOp();
        mid("mdu_c0");
        check("mdu0_start", oMdu_start, 1);
        check("mdu0_stall", oStall, 1);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            mid("mdu_wait");
            check("mduw_start", oMdu_start, 0);
            check("mduw_stall", oStall, 1);
        end
        nextCycle();
        iMdu_done = 1;
        mid("mdu_c4_done");
        check("mdu4_stall", oStall, 0);

        // New MDU op launches at once, proving IDLE; then flush+done in BUSY
        nextCycle();
        mduOp();
        mid("mdu_c5_restart");
        check("mdu5_start", oMdu_start, 1);
        nextCycle();
        mid("flush_busy1");
        check("fb1_stall", oStall, 1);
        nextCycle();
        iFlush = 1; iMdu_done = 1;
        mid("flush_busy2");
        check("fb2_abort", oMdu_abort, 1);
        check("fb2_err", oMdu_err, 0);
        check("fb2_stall", oStall, 0);
        nextCycle();
        idleInputs();
        mid("after_flush");
        check("af_abort", oMdu_abort, 0);
        check("af_cnt", oStallCnt, 7);

        // Flush masks both load-use stall and MDU launch
        nextCycle();
        mduOp();
        iEx_rs1_addr = 4; iEx_rs1_used = 1;
        iExMe_rd_addr = 4; iExMe_wr_en = 1; iExMe_is_load = 1; iFlush = 1;
        mid("flush_gate");
        check("fg_stall", oStall, 0);
        check("fg_bubble", oBubble, 0);
        check("fg_start", oMdu_start, 0);

        // Timeout: done never comes
        nextCycle();
        mduOp();
        mid("to_c0");
        check("to0_start", oMdu_start, 1);
        for (int c = 1; c <= TO - 1; c++) begin
            nextCycle();
            mid("to_wait");
            check("tow_stall", oStall, 1);
            check("tow_err", oMdu_err, 0);
        end
        nextCycle();
        mid("to_c8");
        check("to8_err", oMdu_err, 1);
        check("to8_abort", oMdu_abort, 1);
        check("to8_stall", oStall, 0);
        nextCycle();
        idleInputs();
        mid("to_c9");
        check("to9_err", oMdu_err, 0);
        check("to9_abort", oMdu_abort, 0);
        check("to9_cnt", oStallCnt, 15);

        // One more stall must saturate, not wrap
        nextCycle();
        iEx_valid = 1; iEx_rs1_addr = 2; iEx_rs1_used = 1;
        iExMe_rd_addr = 2; iExMe_wr_en = 1; iExMe_is_load = 1;
        mid("sat_stall");
        check("sat_stall", oStall, 1);
        nextCycle();
        idleInputs();
        mid("sat_after");
        check("sat_cnt", oStallCnt, MAXC);

        // Load-use and MDU op together: load-use first, MDU next cycle
        nextCycle();
        mduOp();
        iEx_rs1_addr = 3; iEx_rs1_used = 1;
        iExMe_rd_addr = 3; iExMe_wr_en = 1; iExMe_is_load = 1;
        mid("co_c0");
        check("co0_start", oMdu_start, 0);
        check("co0_stall", oStall, 1);
        check("co0_bubble", oBubble, 1);
        nextCycle();
        iExMe_rd_addr = 0; iExMe_wr_en = 0; iExMe_is_load = 0;
        iMeWb_rd_addr = 3; iMeWb_wr_en = 1;
        mid("co_c1");
        check("co1_start", oMdu_start, 1);
        check("co1_fwMe1", oFwMeS1_en, 1);
        check("co1_bubble", oBubble, 0);

        // Asynchronous reset mid-BUSY, with a flush that would otherwise abort
        nextCycle();
        #3;
        iRst = 1; iFlush = 1;
        #1;
        $display("[%0t] step rst_mid_busy stall=%0b abort=%0b cnt=%0d", $time, oStall, oMdu_abort, oStallCnt);
        check("rmb_abort", oMdu_abort, 0);
        check("rmb_stall", oStall, 0);
        check("rmb_fwMe1", oFwMeS1_en, 0);
        check("rmb_cnt", oStallCnt, 0);
        nextCycle();
        idleInputs();
        iRst = 0;
        mid("post_reset");
        check("pr_stall", oStall, 0);
        nextCycle();
        mduOp();
        mid("post_reset_mdu");
        check("prm_start", oMdu_start, 1);
        nextCycle();
        idleInputs();
        iFlush = 1;
        mid("post_reset_flush");
        check("prf_abort", oMdu_abort, 1);
        nextCycle();
        idleInputs();
        mid("done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
